// File: rtl/core_pkg.sv
// core_pkg: shared widths, flag indices, buffer state encoding and pipeline entry type
package core_pkg;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
    } entry_t;
endpackage

// File: rtl/flag_reg.sv
// flag_reg: architectural C/Z/N register with masked update; optional save/restore under FLAG_SAVE_EN
module flag_reg #(
    parameter int FLAG_W = core_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              upd_en,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] mask,
`ifdef FLAG_SAVE_EN
    input  logic              save,
    input  logic              restore,
`endif
    output logic [FLAG_W-1:0] flags_q
);
    import core_pkg::*;

    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] upd_flags;
`ifdef FLAG_SAVE_EN
    logic [FLAG_W-1:0] saved_q;
    logic [FLAG_W-1:0] saved_d;
`endif

    // next flags: masked merge on accept; restore overrides it, save snapshots the merged value
    always_comb begin
        upd_flags = upd_en ? (flags_q & ~mask) | (flags_in & mask) : flags_q;
`ifdef FLAG_SAVE_EN
        flags_d = restore ? saved_q : upd_flags;
        saved_d = (save && !restore) ? upd_flags : saved_q;
`else
        flags_d = upd_flags;
`endif
    end

    // flag state registers
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            flags_q <= '0;
`ifdef FLAG_SAVE_EN
            saved_q <= '0;
`endif
        end else begin
            flags_q <= flags_d;
`ifdef FLAG_SAVE_EN
            saved_q <= saved_d;
`endif
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: 2-entry skid buffer between ALU and memory stage, owns flags; FLAG_SAVE_EN adds flag save/restore
module ex_mem_stage #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int REG_W  = core_pkg::REG_W,
    parameter int FLAG_W = core_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [FLAG_W-1:0] in_flag_mask,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wb_en,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    input  logic              flush,
`ifdef FLAG_SAVE_EN
    input  logic              flag_save,
    input  logic              flag_restore,
`endif
    output logic [FLAG_W-1:0] flags_q
);
    import core_pkg::*;

    // entry layout follows core_pkg::entry_t but tracks this instance's widths
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
    } slot_t;

    buf_state_e state_q, state_d;
    slot_t      head_q, head_d, tail_q, tail_d, in_ent;
    logic       accept, pop;

    assign in_ready = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign accept = in_valid && in_ready && !flush;
    assign pop = out_valid && out_ready;
    assign in_ent = '{result: in_result, rd: in_rd, wb_en: in_wb_en, mem_rd: in_mem_rd, mem_wr: in_mem_wr};
    assign out_result = head_q.result;
    assign out_rd = head_q.rd;
    assign out_wb_en = head_q.wb_en;
    assign out_mem_rd = head_q.mem_rd;
    assign out_mem_wr = head_q.mem_wr;

    // occupancy and FIFO slot movement: head is always the oldest entry
    always_comb begin
        state_d = flush ? EMPTY
                : (state_q == EMPTY) ? (accept ? ONE : EMPTY)
                : (state_q == ONE) ? ((accept && !pop) ? TWO : (!accept && pop) ? EMPTY : ONE)
                : (pop ? ONE : TWO);
        head_d = (pop && state_q == TWO) ? tail_q
               : (accept && (state_q == EMPTY || pop)) ? in_ent : head_q;
        tail_d = (accept && state_q == ONE && !pop) ? in_ent : tail_q;
    end

    // buffer registers; reset clears payload so out fields read zero
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state_q <= state_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    flag_reg #(.FLAG_W(FLAG_W)) u_flag_reg (
        .clk(clk),
        .reset_b(reset_b),
        .upd_en(accept),
        .flags_in(in_flags),
        .mask(in_flag_mask),
`ifdef FLAG_SAVE_EN
        .save(flag_save),
        .restore(flag_restore),
`endif
        .flags_q(flags_q)
    );
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage (exercises save/restore when FLAG_SAVE_EN is defined)
module tb_ex_mem_stage;
    logic        clk = 0, reset_b = 0, in_valid = 0, in_wb_en = 0, in_mem_rd = 0, in_mem_wr = 0;
    logic        out_ready = 0, flush = 0;
    logic [15:0] in_result = '0;
    logic [2:0]  in_flags = '0, in_flag_mask = '0, in_rd = '0;
    logic        in_ready, out_valid, out_wb_en, out_mem_rd, out_mem_wr;
    logic [15:0] out_result;
    logic [2:0]  out_rd, flags_q;
`ifdef FLAG_SAVE_EN
    logic        flag_save = 0, flag_restore = 0;
`endif

    ex_mem_stage dut (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_flag_mask(in_flag_mask), .in_rd(in_rd),
        .in_wb_en(in_wb_en), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .flush(flush),
`ifdef FLAG_SAVE_EN
        .flag_save(flag_save), .flag_restore(flag_restore),
`endif
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        wb, mr, mw;
    } exp_t;

    exp_t        exp_q[$];
    int          cnt = 0, n_tests = 0, n_fail = 0;
    logic [2:0]  m_flags = '0, m_saved = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] fl, input logic [2:0] m);
        in_valid = v;
        in_result = res;
        in_flags = fl;
        in_flag_mask = m;
        in_rd = res[2:0];
        in_wb_en = res[0];
        in_mem_rd = res[1];
        in_mem_wr = res[2];
        tick();
    endtask

    // reference model: occupancy, flags and expected-output queue
    always @(posedge clk) begin : mdl
        logic acc, pp;
        logic [2:0] nf;
        if (!reset_b) begin
            cnt = 0;
            m_flags = '0;
            m_saved = '0;
            exp_q.delete();
        end else begin
            acc = in_valid && cnt < 2 && !flush;
            pp = cnt > 0 && out_ready;
            nf = acc ? (m_flags & ~in_flag_mask) | (in_flags & in_flag_mask) : m_flags;
`ifdef FLAG_SAVE_EN
            if (flag_restore) nf = m_saved;
            else if (flag_save) m_saved = nf;
`endif
            m_flags = nf;
            if (flush) begin
                cnt = 0;
                exp_q.delete();
            end else begin
                cnt = cnt + int'(acc) - int'(pp);
                if (acc) exp_q.push_back('{in_result, in_rd, in_wb_en, in_mem_rd, in_mem_wr});
            end
        end
    end

    // monitor: handshake/flag checks every cycle, scoreboard compare on each pop
    always @(negedge clk) begin
        if (reset_b) begin
            chk("out_valid", out_valid, cnt > 0);
            chk("in_ready", in_ready, cnt < 2);
            chk("flags", flags_q, m_flags);
            if (out_valid && out_ready && !flush) begin
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("pop_result", out_result, exp_q[0].res);
                    chk("pop_rd", out_rd, exp_q[0].rd);
                    chk("pop_ctl", {out_wb_en, out_mem_rd, out_mem_wr}, {exp_q[0].wb, exp_q[0].mr, exp_q[0].mw});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        reset_b = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flags", flags_q, 0);
        chk("rst_result", out_result, 0);

        out_ready = 1;
        drive(1, 16'h1234, 3'b011, 3'b111);
        in_valid = 0;
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 16'h1234);
        chk("t1_flags", flags_q, 3'b011);
        tick();

        out_ready = 0;
        drive(1, 16'h0001, 3'b000, 3'b000);
        drive(1, 16'h0002, 3'b000, 3'b000);
        in_valid = 0;
        chk("t2_in_ready", in_ready, 0);
        chk("t2_head", out_result, 16'h0001);
        out_ready = 1;
        tick();
        chk("t2_second", out_result, 16'h0002);
        chk("t2_valid", out_valid, 1);
        tick();
        chk("t2_empty", out_valid, 0);

        drive(1, 16'h0010, 3'b111, 3'b111);
        drive(1, 16'h0011, 3'b000, 3'b110);
        in_valid = 0;
        chk("t3_flags", flags_q, 3'b001);
        tick();

        out_ready = 0;
        drive(1, 16'h0020, 3'b110, 3'b000);
        drive(1, 16'h0021, 3'b110, 3'b000);
        in_valid = 1;
        in_flags = 3'b110;
        in_flag_mask = 3'b111;
        flush = 1;
        tick();
        flush = 0;
        in_valid = 0;
        chk("t4_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_flags", flags_q, 3'b001);

`ifdef FLAG_SAVE_EN
        out_ready = 1;
        flag_save = 1;
        drive(1, 16'h0030, 3'b101, 3'b111);
        flag_save = 0;
        chk("t5_flags_a", flags_q, 3'b101);
        drive(1, 16'h0031, 3'b010, 3'b111);
        chk("t5_flags_b", flags_q, 3'b010);
        flag_restore = 1;
        drive(1, 16'h0032, 3'b111, 3'b111);
        flag_restore = 0;
        in_valid = 0;
        chk("t5_restore", flags_q, 3'b101);
        tick();
`endif

        out_ready = 0;
        drive(1, 16'h00a5, 3'b110, 3'b111);
        drive(1, 16'h00a6, 3'b110, 3'b111);
        in_valid = 0;
        chk("t6_full", in_ready, 0);
        reset_b = 0;
        tick();
        reset_b = 1;
        chk("t6_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_flags", flags_q, 0);
        chk("t6_result", out_result, 0);
        chk("t6_fields", {out_rd, out_wb_en, out_mem_rd, out_mem_wr}, 0);

        for (int i = 0; i < 200; i++) begin
            flush = ($urandom % 16) == 0;
            out_ready = $urandom % 4 != 0;
`ifdef FLAG_SAVE_EN
            flag_save = ($urandom % 8) == 0;
            flag_restore = ($urandom % 8) == 0;
`endif
            drive($urandom % 3 != 0, 16'($urandom), 3'($urandom), 3'($urandom));
        end
        flush = 0;
        in_valid = 0;
        out_ready = 1;
`ifdef FLAG_SAVE_EN
        flag_save = 0;
        flag_restore = 0;
`endif
        repeat (4) tick();
        chk("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
